// File: rtl/vector_sweeper.sv
// Purpose: sweeps a stimulus vector (binary, gray or walking-one) and compacts responses into a 16-bit MISR.
// Latency: first vector appears one cycle after an accepted start; done rises NVEC*DWELL cycles after start.
// Backpressure: none; start is ignored while a sweep runs, abort terminates it immediately.
module vector_sweeper #(
    parameter int          WIDTH  = 3,
    parameter int          RESP_W = 2,
    parameter int          DWELL  = 10,
    parameter logic [15:0] POLY   = 16'h1021
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [RESP_W-1:0] resp_in,
    output logic [WIDTH-1:0]  stim_out,
    output logic              stim_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       signature,
    output logic [16:0]       vec_count
);

    // Dwell counter needs at least one bit even when every vector lasts a single cycle.
    localparam int             DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [WIDTH:0] LAST_BIN   = (WIDTH + 1)'((1 << WIDTH) - 1);
    localparam logic [WIDTH:0] LAST_WALK  = (WIDTH + 1)'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [1:0]     mode_q;
    logic [WIDTH:0] idx;
    logic [DCW-1:0] dwell_cnt;
    logic [WIDTH:0] idx_next;
    logic [15:0]    sig_next;

    // Vector for a given pattern and index; modes 0 and 3 are both plain binary.
    function automatic logic [WIDTH-1:0] vec_of(input logic [1:0] m, input logic [WIDTH:0] i);
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] one;
        b      = i[WIDTH-1:0];
        one    = '0;
        one[0] = 1'b1;
        case (m)
            2'd1:    vec_of = b ^ (b >> 1);
            2'd2:    vec_of = one << i;
            default: vec_of = b;
        endcase
    endfunction

    // Index of the final vector; the index counter is one bit wider so it never wraps early.
    function automatic logic [WIDTH:0] last_of(input logic [1:0] m);
        last_of = (m == 2'd2) ? LAST_WALK : LAST_BIN;
    endfunction

    // Next index and next MISR value for the sample taken at the end of a dwell period.
    always_comb begin
        idx_next = idx + 1'b1;
        sig_next = {signature[14:0], 1'b0} ^ (signature[15] ? POLY : 16'h0000) ^ 16'(resp_in);
    end

    // Sweep state machine with every output registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_q     <= 2'd0;
            idx        <= '0;
            dwell_cnt  <= '0;
            stim_out   <= '0;
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            signature  <= 16'h0000;
            vec_count  <= 17'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (abort) begin
                        // Abort outranks a simultaneous start and clears a pending done.
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state      <= S_RUN;
                        mode_q     <= mode;
                        idx        <= '0;
                        dwell_cnt  <= '0;
                        stim_out   <= vec_of(mode, '0);
                        stim_valid <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        signature  <= 16'h0000;
                        vec_count  <= 17'd0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Signature and vec_count stay frozen at their values for inspection.
                        state      <= S_IDLE;
                        idx        <= '0;
                        dwell_cnt  <= '0;
                        stim_out   <= '0;
                        stim_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        signature <= sig_next;
                        vec_count <= vec_count + 17'd1;
                        dwell_cnt <= '0;
                        if (idx == last_of(mode_q)) begin
                            state      <= S_DONE;
                            idx        <= '0;
                            stim_out   <= '0;
                            stim_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            idx      <= idx_next;
                            stim_out <= vec_of(mode_q, idx_next);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_sweeper.sv
// Purpose: directed self-checking bench for vector_sweeper (default build plus a DWELL=1 build).
// Latency: all checks sampled 1 time unit after the rising clock edge.
// Backpressure: not applicable; inputs are driven from a single linear initial block.
module tb_vector_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        use_stim;
    logic [1:0]  mode;
    logic [1:0]  resp;
    logic [2:0]  stim;
    logic        stim_valid;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [16:0] vec_count;

    logic        start_f;
    logic [2:0]  stim_f;
    logic        valid_f;
    logic        busy_f;
    logic        done_f;
    logic [15:0] sig_f;
    logic [16:0] cnt_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Response loop-back: either zero or the low two bits of the current vector.
    assign resp = use_stim ? stim[1:0] : 2'b00;

    vector_sweeper u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .resp_in    (resp),
        .stim_out   (stim),
        .stim_valid (stim_valid),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    vector_sweeper #(.DWELL(1)) u_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_f),
        .abort      (1'b0),
        .mode       (2'b00),
        .resp_in    (2'b00),
        .stim_out   (stim_f),
        .stim_valid (valid_f),
        .busy       (busy_f),
        .done       (done_f),
        .signature  (sig_f),
        .vec_count  (cnt_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-written vector tables for WIDTH=3.
    function automatic logic [2:0] exp_vec(input logic [1:0] m, input int i);
        if (m == 2'd1) begin
            case (i)
                0: return 3'd0;
                1: return 3'd1;
                2: return 3'd3;
                3: return 3'd2;
                4: return 3'd6;
                5: return 3'd7;
                6: return 3'd5;
                default: return 3'd4;
            endcase
        end else if (m == 2'd2) begin
            case (i)
                0: return 3'd1;
                1: return 3'd2;
                default: return 3'd4;
            endcase
        end
        return 3'(i);
    endfunction

    // One complete sweep with DWELL=10; poke re-issues start mid-run to prove it is ignored.
    task automatic sweep(input logic [1:0] m, input int nvec, input logic [15:0] exp_sig, input bit poke);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_vec", stim, exp_vec(m, 0));
        chk("start_valid", stim_valid, 1);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_cnt", vec_count, 0);
        chk("start_sig", signature, 0);
        for (int k = 1; k < nvec * 10; k++) begin
            step();
            start = 1'b0;
            chk("run_vec", stim, exp_vec(m, k / 10));
            chk("run_done", done, 0);
            if (poke && k == 35) begin
                start = 1'b1;
                mode  = 2'd2;
            end
        end
        step();
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", stim_valid, 0);
        chk("end_stim", stim, 0);
        chk("end_cnt", vec_count, nvec);
        chk("end_sig", signature, exp_sig);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        mode     = 2'd0;
        use_stim = 1'b0;
        start_f  = 1'b0;
        step();
        step();
        chk("rst_stim", stim, 0);
        chk("rst_valid", stim_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sig", signature, 0);
        chk("rst_cnt", vec_count, 0);
        chk("rst_fast_busy", busy_f, 0);
        rst_n = 1'b1;
        step();

        // Binary sweep with zero responses, then done must hold.
        sweep(2'd0, 8, 16'h0000, 1'b0);
        repeat (5) step();
        chk("done_hold", done, 1);
        chk("done_hold_cnt", vec_count, 8);

        // Gray sweep with a start pulse injected mid-run.
        sweep(2'd1, 8, 16'h0000, 1'b1);

        // Walking-one sweep: three vectors, done after 30 cycles.
        sweep(2'd2, 3, 16'h0000, 1'b0);

        // Responses 0,1,2,3,0,1,2,3 give MISR 0,1,0,3,6,D,18,33; a restart reproduces it.
        use_stim = 1'b1;
        sweep(2'd0, 8, 16'h0033, 1'b0);
        sweep(2'd0, 8, 16'h0033, 1'b0);

        // Abort in DONE returns to IDLE and clears done.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done_done", done, 0);
        chk("abort_done_busy", busy, 0);

        // Abort sampled at cycle 25 of a binary run: two samples taken (resp 0 then 1).
        mode  = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 25; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", stim_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_stim", stim, 0);
        chk("abort_cnt", vec_count, 2);
        chk("abort_sig", signature, 16'h0001);

        // Abort together with start stays in IDLE.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abtstart_busy", busy, 0);
        chk("abtstart_valid", stim_valid, 0);
        chk("abtstart_done", done, 0);
        step();
        chk("abtstart_busy2", busy, 0);

        // Reset asserted at cycle 40 of a run clears every output at once.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 40; k++) step();
        chk("prerst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stim", stim, 0);
        chk("midrst_valid", stim_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sig", signature, 0);
        chk("midrst_cnt", vec_count, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("postrst_busy", busy, 0);
        chk("postrst_valid", stim_valid, 0);

        // DWELL=1 build: a new vector every cycle, done eight cycles after start.
        start_f = 1'b1;
        step();
        start_f = 1'b0;
        chk("fast_vec0", stim_f, 0);
        chk("fast_valid0", valid_f, 1);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("fast_vec", stim_f, k);
            chk("fast_valid", valid_f, 1);
            chk("fast_done", done_f, 0);
        end
        step();
        chk("fast_end_done", done_f, 1);
        chk("fast_end_valid", valid_f, 0);
        chk("fast_end_cnt", cnt_f, 8);
        chk("fast_end_sig", sig_f, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_sweeper.md
VECTOR_SWEEPER -- requirements
Module: vector_sweeper

Interface
REQ-001 SHALL have parameter WIDTH, default 3, stimulus vector width (1..16).
REQ-002 SHALL have parameter RESP_W, default 2, response width (1..16).
REQ-003 SHALL have parameter DWELL, default 10, clock cycles each vector is held (>=1).
REQ-004 SHALL have parameter POLY, default 16'h1021, signature feedback polynomial.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  sweep request, sampled at the clk edge.
REQ-009 SHALL have port abort  input  1  terminate the sweep.
REQ-010 SHALL have port mode  input  2  sweep pattern: 0 binary, 1 gray, 2 walking-one, 3 binary.
REQ-011 SHALL have port resp_in  input  RESP_W  response from the device under test.
REQ-012 SHALL have port stim_out  output  WIDTH  current stimulus vector.
REQ-013 SHALL have port stim_valid  output  1  stim_out is a live vector.
REQ-014 SHALL have port busy  output  1  sweep in progress.
REQ-015 SHALL have port done  output  1  sweep completed, held high until the next start.
REQ-016 SHALL have port signature  output  16  MISR of all sampled responses.
REQ-017 SHALL have port vec_count  output  17  number of vectors sampled this sweep.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE, all outputs registered.
REQ-019 SHALL accept start only in IDLE or DONE, latching mode at that edge; start in RUN SHALL be ignored.
REQ-020 On an accepted start: next state RUN; stim_out = first vector; stim_valid=1; busy=1; done=0; signature=0; vec_count=0; dwell counter=0.
REQ-021 SHALL generate the vector sequence per mode. Binary: i = 0..2^WIDTH-1. Gray: i^(i>>1) for the same i. Walking-one: 1<<i for i = 0..WIDTH-1.
REQ-022 SHALL hold each vector for exactly DWELL cycles; the dwell counter runs 0..DWELL-1.
REQ-023 In the cycle where the dwell counter = DWELL-1, SHALL sample resp_in at that edge, increment vec_count and load the next vector.
REQ-024 Signature update at each sample SHALL be: sig <= ({sig[14:0],0} ^ (sig[15] ? POLY : 0)) ^ zero-extended resp_in.
REQ-025 After the last vector is sampled: state DONE; stim_valid=0; busy=0; done=1; stim_out=0; signature and vec_count held.
REQ-026 Total RUN duration SHALL be NVEC*DWELL cycles: NVEC = 2^WIDTH for binary and gray, WIDTH for walking-one.
REQ-027 Counter wrap: the index counter is WIDTH+1 bits and SHALL NOT wrap before the last vector.
REQ-028 abort in RUN: next state IDLE; stim_valid=0; busy=0; done=0; stim_out=0; signature and vec_count frozen.
REQ-029 abort and start asserted together: abort SHALL win, and the state SHALL go to or stay in IDLE.
REQ-030 abort in IDLE SHALL have no effect; abort in DONE SHALL return to IDLE with done=0.
REQ-031 DWELL=1 SHALL produce a new vector every cycle with no gap cycles.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE with stim_out=0, stim_valid=0, busy=0, done=0, signature=0, vec_count=0, and the dwell and index counters at 0.
REQ-033 Reset asserted mid-RUN SHALL discard the sweep; after release, a new start SHALL be required.

Verification
REQ-034 Defaults, mode=0, start pulse, resp_in=0 -> stim_out 0,1,...,7, each held 10 cycles; done rises 80 cycles after start; vec_count=8; signature=16'h0000.
REQ-035 mode=1 -> stim_out sequence 0,1,3,2,6,7,5,4; vec_count=8.
REQ-036 mode=2 -> stim_out sequence 1,2,4; done after 30 cycles; vec_count=3.
REQ-037 resp_in = stim_out[1:0] in mode 0 -> signature matches the bit-accurate model of REQ-024; a second start clears and reproduces the same value.
REQ-038 abort in cycle 25 of a mode-0 run -> next cycle IDLE, stim_valid=0, done=0, vec_count=2; an abort+start pulse leaves the state IDLE.
REQ-039 rst_n low in cycle 40 of a run -> all outputs are 0 immediately; start in RUN ignored; DWELL=1 build -> 8 consecutive vectors, done at cycle 8.
